event_led_driver: RTL and testbench
===================================

EVENT_LED_DRIVER -- requirements
Module: event_led_driver

Interface
REQ-001 The block SHALL expose parameter ON_CYCLES, default 10_000_000, meaning LED-on duration per event in clk cycles (minimum 1).
REQ-002 The block SHALL expose parameter GAP_CYCLES, default 5_000_000, meaning the forced LED-off time between consecutive events in clk cycles (minimum 1).
REQ-003 The block SHALL expose parameter CNT_W, default 4, meaning the width of the pending-event counter.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 i_evt  input  1  one-cycle event pulse, e.g. a debounced button pulse; each high cycle is one event.
REQ-007 o_led  output  1  stretched, visible indicator level; high during the ON state.
REQ-008 o_busy  output  1  high whenever state is not IDLE.
REQ-009 o_pending  output  CNT_W  count of accepted events not yet displayed.
REQ-010 o_overflow  output  1  sticky flag; set when an event is lost.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, ON and GAP.
REQ-012 IDLE with i_evt=1 SHALL go to ON on the next edge, and o_led SHALL be high from that edge; o_pending is unchanged.
REQ-013 IDLE with o_pending>0 SHALL go to ON on the next edge and decrement o_pending by 1.
REQ-014 ON SHALL hold o_led high for exactly ON_CYCLES cycles, then enter GAP.
REQ-015 GAP SHALL hold o_led low for exactly GAP_CYCLES cycles.
REQ-016 At the end of GAP, with o_pending>0, the FSM SHALL go to ON and decrement o_pending; otherwise it SHALL go to IDLE.
REQ-017 An i_evt arriving in ON or GAP, or in IDLE while o_pending>0, SHALL increment o_pending.
REQ-018 An increment and a decrement in the same cycle SHALL leave o_pending unchanged.
REQ-019 o_pending SHALL saturate at 2^CNT_W-1; an increment at saturation SHALL be dropped and SHALL set o_overflow.
REQ-020 o_overflow SHALL stay set until reset.
REQ-021 Any timer count SHALL be ON_CYCLES-1 or GAP_CYCLES-1, reloaded on each state entry; its width SHALL be $clog2 of the larger parameter, minimum 1.
REQ-022 All outputs SHALL be registered, with no combinational path from i_evt to any output.

Reset
REQ-023 Asserting rst low SHALL immediately force state=IDLE, o_led=0, o_busy=0, o_pending=0, o_overflow=0 and clear the timer, including mid-ON and mid-GAP.
REQ-024 After rst is released, the first i_evt SHALL be treated as in REQ-012.

Configuration
REQ-025 Macro EVENT_LED_QUEUE_EN SHALL compile in event queuing.
REQ-026 When EVENT_LED_QUEUE_EN is defined, REQ-013, REQ-016, REQ-017, REQ-018 and REQ-019 SHALL apply.
REQ-027 When EVENT_LED_QUEUE_EN is undefined:
- an i_evt arriving outside IDLE SHALL be dropped and SHALL set o_overflow;
- o_pending SHALL be constant 0;
- GAP SHALL always return to IDLE.

Structure
REQ-028 Package event_led_pkg SHALL hold the state enum typedef (IDLE, ON, GAP) and the default ON/GAP/CNT_W constants.
REQ-029 The cycle timer SHALL be a sub-module, event_led_timer, with ports load, load value, enable and done (done = count==0).
REQ-030 The FSM, pending counter and overflow flag SHALL be in event_led_driver.

Verification (ON_CYCLES=4, GAP_CYCLES=2, CNT_W=2)
REQ-031 Single event: i_evt pulse at cycle 10 -> o_led high cycles 11-14, low 15-16, o_busy low from 17, o_pending=0.
REQ-032 Queued events: pulses at cycles 10, 12, 13 -> o_pending=2 at 14; ON bursts at 11-14, 17-20, 23-26; o_pending=0 after 23.
REQ-033 Simultaneous event and GAP-end decrement: o_pending held at 1 across that edge.
REQ-034 Saturation: 5 pulses during one ON -> o_pending=3, o_overflow=1 and sticky; 4 ON bursts total.
REQ-035 Reset mid-ON: rst low at cycle 12 of a burst starting at 11 -> o_led=0 and o_pending=0 asynchronously; the next event restarts per REQ-012.
REQ-036 Queue compiled out (EVENT_LED_QUEUE_EN undefined): pulses at cycles 10 and 12 -> one burst only, o_overflow=1.

Source files
------------

// File: rtl/event_led_pkg.sv
// Shared types and default constants for the event LED driver.
// Defines the FSM state enum and the timer-width helper.
package event_led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int unsigned DEF_ON_CYCLES  = 10_000_000;
  localparam int unsigned DEF_GAP_CYCLES = 5_000_000;
  localparam int unsigned DEF_CNT_W      = 4;

  // Bits needed to hold (max-1) of the two durations, never less than one.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    int unsigned w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/event_led_if.sv
// Event input / indicator output bundle for event_led_driver.
// slave = driver side, master = whoever produces events and watches the LED.
interface event_led_if
  import event_led_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
);

  logic             i_evt;
  logic             o_led;
  logic             o_busy;
  logic [CNT_W-1:0] o_pending;
  logic             o_overflow;

  modport master (
    output i_evt,
    input  o_led,
    input  o_busy,
    input  o_pending,
    input  o_overflow
  );

  modport slave (
    input  i_evt,
    output o_led,
    output o_busy,
    output o_pending,
    output o_overflow
  );

endinterface

// File: rtl/event_led_timer.sv
// Down-counting cycle timer: load has priority, counts down while enabled,
// and holds at zero. done_o flags a zero count.
module event_led_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] count_q;

  // NOTE: sequential state is only ever written with <= so every flop samples
  // the pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/event_led_driver.sv
// Stretches one-cycle event pulses into visible ON/GAP LED bursts.
// Define EVENT_LED_QUEUE_EN to queue events that arrive while busy.
module event_led_driver
  import event_led_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = DEF_ON_CYCLES,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  event_led_if.slave bus
);

  localparam int unsigned TMR_W = timer_width(ON_CYCLES, GAP_CYCLES);
  localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);

  state_e           state_q, state_d;
  logic             led_q, busy_q, ovf_q;
  logic             ovf_set;
  logic             pend_nz;
  logic             evt_queued;
  logic             tmr_load, tmr_done;
  logic [TMR_W-1:0] tmr_val;

  event_led_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (state_q != IDLE),
    .done_o     (tmr_done)
  );

  // An event that does not start a burst directly must go through the queue.
  assign evt_queued = bus.i_evt && ((state_q != IDLE) || pend_nz);

`ifdef EVENT_LED_QUEUE_EN
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  logic [CNT_W-1:0] pending_q, pending_d;
  logic             pend_dec;

  assign pend_nz  = (pending_q != '0);
  assign pend_dec = pend_nz && ((state_q == IDLE) || ((state_q == GAP) && tmr_done));

  always_comb begin
    pending_d = pending_q;
    ovf_set   = 1'b0;
    if (evt_queued && pend_dec) begin
      pending_d = pending_q;
    end else if (evt_queued) begin
      if (pending_q == PEND_MAX) ovf_set = 1'b1;
      else                       pending_d = pending_q + 1'b1;
    end else if (pend_dec) begin
      pending_d = pending_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending_q <= '0;
    else      pending_q <= pending_d;
  end

  assign bus.o_pending = pending_q;
`else
  assign pend_nz       = 1'b0;
  assign ovf_set       = evt_queued;
  assign bus.o_pending = {CNT_W{1'b0}};
`endif

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = ON_LOAD;
    unique case (state_q)
      IDLE: begin
        if (pend_nz || bus.i_evt) begin
          state_d  = ON;
          tmr_load = 1'b1;
          tmr_val  = ON_LOAD;
        end
      end
      ON: begin
        if (tmr_done) begin
          state_d  = GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
        end
      end
      GAP: begin
        if (tmr_done) begin
          if (pend_nz) begin
            state_d  = ON;
            tmr_load = 1'b1;
            tmr_val  = ON_LOAD;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= (state_d == ON);
      busy_q  <= (state_d != IDLE);
      ovf_q   <= ovf_q | ovf_set;
    end
  end

  assign bus.o_led      = led_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_event_led_driver.sv
// Directed bench for event_led_driver with ON=4, GAP=2, CNT_W=2.
// Queue scenarios build only with EVENT_LED_QUEUE_EN; the drop scenario otherwise.
module tb_event_led_driver;

  localparam int N = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  event_led_if #(.CNT_W(2)) bus ();

  event_led_driver #(
    .ON_CYCLES  (4),
    .GAP_CYCLES (2),
    .CNT_W      (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [N-1:0] led_tr, busy_tr, ovf_tr;
  logic [1:0]   pend_tr [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] rng(input int lo, input int hi);
    logic [N-1:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [1:0] pend_any();
    logic [1:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++) acc = acc | pend_tr[i];
    return acc;
  endfunction

  // Cycle c: drive i_evt=evt[c], sample outputs on the falling edge, then step.
  task automatic run(input logic [N-1:0] evt);
    for (int c = 0; c < N; c++) begin
      bus.i_evt = evt[c];
      @(negedge clk);
      led_tr[c]  = bus.o_led;
      busy_tr[c] = bus.o_busy;
      ovf_tr[c]  = bus.o_overflow;
      pend_tr[c] = bus.o_pending;
      @(posedge clk);
      #1;
    end
    bus.i_evt = 1'b0;
  endtask

  initial begin
    bus.i_evt = 1'b0;
    rst       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_led",  64'(bus.o_led),      64'd0);
    check("rst_busy", 64'(bus.o_busy),     64'd0);
    check("rst_pend", 64'(bus.o_pending),  64'd0);
    check("rst_ovf",  64'(bus.o_overflow), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single event
    run(rng(10, 10));
    check("single_led",  64'(led_tr),     64'(rng(11, 14)));
    check("single_busy", 64'(busy_tr),    64'(rng(11, 16)));
    check("single_ovf",  64'(ovf_tr),     64'd0);
    check("single_pend", 64'(pend_any()), 64'd0);

`ifdef EVENT_LED_QUEUE_EN
    // Two queued events behind the first
    run(rng(10, 10) | rng(12, 13));
    check("q_led",    64'(led_tr), 64'(rng(11, 14) | rng(17, 20) | rng(23, 26)));
    check("q_pend14", 64'(pend_tr[14]), 64'd2);
    check("q_pend17", 64'(pend_tr[17]), 64'd1);
    check("q_pend23", 64'(pend_tr[23]), 64'd0);
    check("q_ovf",    64'(ovf_tr), 64'd0);

    // Event coincides with the GAP-end decrement
    run(rng(10, 10) | rng(12, 12) | rng(16, 16));
    check("sim_pend16", 64'(pend_tr[16]), 64'd1);
    check("sim_pend17", 64'(pend_tr[17]), 64'd1);
    check("sim_pend23", 64'(pend_tr[23]), 64'd0);
    check("sim_led",    64'(led_tr), 64'(rng(11, 14) | rng(17, 20) | rng(23, 26)));
    check("sim_busy",   64'(busy_tr), 64'(rng(11, 28)));

    // Saturation: pulses every cycle from 10 to 14
    run(rng(10, 14));
    check("sat_pend14", 64'(pend_tr[14]), 64'd3);
    check("sat_pend15", 64'(pend_tr[15]), 64'd3);
    check("sat_pend29", 64'(pend_tr[29]), 64'd0);
    check("sat_ovf",    64'(ovf_tr), 64'(rng(15, N - 1)));
    check("sat_led",    64'(led_tr),
          64'(rng(11, 14) | rng(17, 20) | rng(23, 26) | rng(29, 32)));
`else
    // Second event lands mid-burst and is dropped
    run(rng(10, 10) | rng(12, 12));
    check("drop_led",  64'(led_tr),     64'(rng(11, 14)));
    check("drop_busy", 64'(busy_tr),    64'(rng(11, 16)));
    check("drop_ovf",  64'(ovf_tr),     64'(rng(13, N - 1)));
    check("drop_pend", 64'(pend_any()), 64'd0);
`endif

    // Asynchronous reset during ON
    check("pre_rst_ovf", 64'(bus.o_overflow), 64'd1);
    bus.i_evt = 1'b1;
    @(posedge clk);
    #1;
    bus.i_evt = 1'b0;
    @(posedge clk);
    #1;
    check("mid_on_led", 64'(bus.o_led), 64'd1);
    rst = 1'b0;
    #1;
    check("arst_led",  64'(bus.o_led),      64'd0);
    check("arst_busy", 64'(bus.o_busy),     64'd0);
    check("arst_pend", 64'(bus.o_pending),  64'd0);
    check("arst_ovf",  64'(bus.o_overflow), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    run(rng(10, 10));
    check("after_rst_led",  64'(led_tr),  64'(rng(11, 14)));
    check("after_rst_busy", 64'(busy_tr), 64'(rng(11, 16)));
    check("after_rst_ovf",  64'(ovf_tr),  64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
